sx_bus_bridge: RTL
==================

// Module: sx_bus_bridge
// PURPOSE
//  Parametrised 386SX local-bus cycle controller; successor to the fixed-map bridge.
//  Captures each CPU bus cycle and decodes it against NUM_TGT address windows.
//  Drives one target per cycle, in fixed-wait or req/valid handshake mode.
//  Generates a one-clock READY#. Times out hung targets; reports unmapped accesses.
// PARAMETERS
//  AW        24              CPU address width (bit0 unused, 16-bit bus)
//  DW        16              data width
//  NUM_TGT   4               number of target windows
//  TGT_BASE  {AW*NUM_TGT}    packed window bases, target i at [AW*i +: AW]
//  TGT_MASK  {AW*NUM_TGT}    packed masks; hit_i = ((addr & MASK_i) == BASE_i)
//  TGT_HS    {NUM_TGT}       per-target mode: 1 = handshake (waitreq/valid), 0 = fixed wait
//  TGT_WAIT  {4*NUM_TGT}     fixed-mode wait clocks, 0..15
//  IO_WAIT   4               wait clocks for I/O, halt and unmapped cycles
//  TIMEOUT   255             clocks from strobe issue to forced completion (8-bit)
// PORTS
//  clk        in   1            bus clock (CPU CLK2 domain)
//  reset_n    in   1            asynchronous, active-low reset
//  ads_n      in   1            CPU address strobe
//  mio        in   1            memory(1) / IO(0)
//  dc         in   1            data(1) / control(0)
//  wr         in   1            write(1) / read(0)
//  be_n       in   2            CPU byte enables {BHE#, BLE#}
//  addr       in   AW           CPU address
//  cpu_wdata  in   DW           CPU write data
//  cpu_rdata  out  DW           read data to CPU; valid while ready_n = 0
//  ready_n    out  1            READY# to CPU
//  na_n       out  1            tied 1 (no pipelining)
//  tgt_sel    out  NUM_TGT      one-hot selected target; held for the whole cycle
//  tgt_addr   out  AW-1         latched addr[AW-1:1]
//  tgt_be_n   out  2            latched byte enables
//  tgt_wdata  out  DW           latched write data
//  tgt_rd     out  1            one-clock read strobe
//  tgt_wr     out  1            one-clock write strobe
//  tgt_waitreq in  NUM_TGT      target stall; the strobe is held off while the selected bit is 1
//  tgt_valid  in   NUM_TGT      handshake read data valid
//  tgt_rdata  in   DW*NUM_TGT   packed target read data
//  err_clr    in   1            clears sticky error flags
//  err_timeout out 1            sticky: a cycle was timed out
//  err_unmap  out  1            sticky: a memory cycle hit no window
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset values: ready_n=1, na_n=1, tgt_rd=0, tgt_wr=0, tgt_sel=0, cpu_rdata=0,
//   err_*=0, busy=0, state=IDLE. Reset mid-cycle aborts immediately with no READY#.
//  FSM:
//   IDLE --(ads_n==0 at edge E0)--> LATCH. At E0, latch addr, be_n, mio, dc, wr;
//    decode hit; lowest index wins on overlapping windows.
//   LATCH --> ISSUE. At E1, latch cpu_wdata.
//    Route to SPECIAL if mio==0, or if it is a halt/control cycle, or if no window hit.
//    err_unmap is set only for an unmapped memory cycle.
//   ISSUE: tgt_rd/tgt_wr is high for the one clock in which waitreq[sel]==0, then -> WAIT.
//   WAIT, fixed mode: count TGT_WAIT[sel] clocks, then latch tgt_rdata[sel] -> DONE.
//    A wait of 0 latches data on the clock after the strobe.
//   WAIT, handshake read: latch rdata on the clock tgt_valid[sel]==1 -> DONE.
//    Handshake write completes -> DONE on strobe acceptance.
//   SPECIAL: count IO_WAIT clocks -> DONE; cpu_rdata = all ones.
//   DONE: ready_n=0 for exactly one clock -> IDLE; tgt_sel cleared on exit.
//  Handshake latency: ADS#-sampled edge to READY# low is 3 clocks minimum
//   (LATCH, ISSUE, DONE) plus stall/wait.
//  Timeout: an 8-bit counter starts at ISSUE entry and covers ISSUE+WAIT.
//   Reaching TIMEOUT forces DONE with rdata all ones, sets err_timeout,
//   and never issues a late strobe.
//  ads_n is ignored outside IDLE (no pipelined cycles).
//  tgt_valid arriving outside WAIT, or for an unselected target, is ignored.
//  err_clr and a same-clock error set: set wins.
// TESTING
//  1 Fixed target, TGT_WAIT=2, read 0xFFFFF0 -> one tgt_rd pulse; ready_n low 1 clk at E0+5;
//    cpu_rdata = tgt_rdata.
//  2 Handshake write, waitreq high 3 clks -> tgt_wr held off, then a single pulse;
//    ready_n low 1 clk after the pulse; tgt_wdata = cpu_wdata sampled at E1.
//  3 Handshake read, valid never asserted, TIMEOUT=8 -> READY# at timeout; rdata 0xFFFF;
//    err_timeout=1 until err_clr.
//  4 Memory read at unmapped 0x900000 -> no strobe; ready_n after IO_WAIT; rdata 0xFFFF;
//    err_unmap=1. IO write -> same with no error flag.
//  5 Overlapping windows 0 and 1 hit -> tgt_sel=0001. ads_n pulsed during WAIT -> ignored.
//  6 reset_n low during WAIT -> ready_n=1, tgt_sel=0, busy=0 asynchronously;
//    the next cycle after reset completes normally.

Source files
------------

// File: rtl/sx_bus_bridge.sv
// 386SX local-bus cycle controller: decodes each CPU bus cycle against NUM_TGT windows,
// runs one target access (fixed wait or waitreq/valid handshake) and returns a one-clock READY#.
module sx_bus_bridge #(
  parameter int AW = 24,
  parameter int DW = 16,
  parameter int NUM_TGT = 4,
  parameter logic [AW*NUM_TGT-1:0] TGT_BASE = {24'hC00000, 24'h100000, 24'h000000, 24'hFE0000},
  parameter logic [AW*NUM_TGT-1:0] TGT_MASK = {24'hFF0000, 24'hF00000, 24'hF00000, 24'hFE0000},
  parameter logic [NUM_TGT-1:0]    TGT_HS   = 4'b0100,
  parameter logic [4*NUM_TGT-1:0]  TGT_WAIT = {4'd2, 4'd0, 4'd1, 4'd3},
  parameter int IO_WAIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ads_n,
  input  logic                  mio,
  input  logic                  dc,
  input  logic                  wr,
  input  logic [1:0]            be_n,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         cpu_wdata,
  output logic [DW-1:0]         cpu_rdata,
  output logic                  ready_n,
  output logic                  na_n,
  output logic [NUM_TGT-1:0]    tgt_sel,
  output logic [AW-2:0]         tgt_addr,
  output logic [1:0]            tgt_be_n,
  output logic [DW-1:0]         tgt_wdata,
  output logic                  tgt_rd,
  output logic                  tgt_wr,
  input  logic [NUM_TGT-1:0]    tgt_waitreq,
  input  logic [NUM_TGT-1:0]    tgt_valid,
  input  logic [DW*NUM_TGT-1:0] tgt_rdata,
  input  logic                  err_clr,
  output logic                  err_timeout,
  output logic                  err_unmap,
  output logic                  busy
);

  localparam int IW      = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int TO_CLKS = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int IO_CLKS = (IO_WAIT < 1) ? 1 : IO_WAIT;
  localparam logic [7:0] TO_LAST = 8'(TO_CLKS - 1);
  localparam logic [7:0] IO_LAST = 8'(IO_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_SPECIAL, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_idx_q;
  logic            wr_q, special_q, unmap_q;
  logic [7:0]      wcnt_q, tcnt_q;

  logic [NUM_TGT-1:0] hit, dec_oh;
  logic [IW-1:0]      dec_idx;
  logic               dec_found, cyc_mem;

  logic          sel_waitreq, sel_valid, sel_hs, to_hit;
  logic [DW-1:0] sel_rdata;
  logic [7:0]    sel_wait;

  logic strobe, cap_rdata, force_ones, set_to, set_unmap;

  // Address decode; the descending scan leaves the lowest matching window selected.
  always_comb begin
    hit       = '0;
    dec_oh    = '0;
    dec_idx   = '0;
    dec_found = 1'b0;
    for (int i = 0; i < NUM_TGT; i++)
      hit[i] = ((addr & TGT_MASK[AW*i +: AW]) == TGT_BASE[AW*i +: AW]);
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_oh    = '0;
        dec_oh[i] = 1'b1;
        dec_idx   = IW'(i);
        dec_found = 1'b1;
      end
    end
  end

  // Memory data or code cycle; halt/shutdown (M/IO=1, D/C=0, W/R=1) is not a target access.
  assign cyc_mem = mio & (dc | ~wr);

  assign sel_waitreq = tgt_waitreq[sel_idx_q];
  assign sel_valid   = tgt_valid[sel_idx_q];
  assign sel_hs      = TGT_HS[sel_idx_q];
  assign sel_rdata   = tgt_rdata[sel_idx_q*DW +: DW];
  assign sel_wait    = 8'(TGT_WAIT[sel_idx_q*4 +: 4]);
  assign to_hit      = (tcnt_q == TO_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    strobe     = 1'b0;
    cap_rdata  = 1'b0;
    force_ones = 1'b0;
    set_to     = 1'b0;
    set_unmap  = 1'b0;
    case (state_q)
      S_IDLE:
        if (!ads_n) state_d = S_LATCH;
      S_LATCH: begin
        set_unmap = unmap_q;
        state_d   = special_q ? S_SPECIAL : S_ISSUE;
      end
      S_ISSUE:
        // Timeout is checked first so a target releasing waitreq late never sees a strobe.
        if (to_hit) begin
          force_ones = 1'b1;
          set_to     = 1'b1;
          state_d    = S_DONE;
        end else if (!sel_waitreq) begin
          strobe  = 1'b1;
          state_d = (sel_hs && wr_q) ? S_DONE : S_WAIT;
        end
      S_WAIT:
        if (to_hit) begin
          force_ones = 1'b1;
          set_to     = 1'b1;
          state_d    = S_DONE;
        end else if (sel_hs) begin
          if (sel_valid) begin
            cap_rdata = 1'b1;
            state_d   = S_DONE;
          end
        end else if (wcnt_q == sel_wait) begin
          cap_rdata = ~wr_q;
          state_d   = S_DONE;
        end
      S_SPECIAL:
        if (wcnt_q == IO_LAST) begin
          force_ones = 1'b1;
          state_d    = S_DONE;
        end
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_idx_q   <= '0;
      wr_q        <= 1'b0;
      special_q   <= 1'b0;
      unmap_q     <= 1'b0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      tgt_sel     <= '0;
      tgt_addr    <= '0;
      tgt_be_n    <= '0;
      tgt_wdata   <= '0;
      cpu_rdata   <= '0;
      err_timeout <= 1'b0;
      err_unmap   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && !ads_n) begin
        tgt_addr  <= addr[AW-1:1];
        tgt_be_n  <= be_n;
        wr_q      <= wr;
        sel_idx_q <= dec_idx;
        tgt_sel   <= cyc_mem ? dec_oh : '0;
        special_q <= ~cyc_mem | ~dec_found;
        unmap_q   <= cyc_mem & ~dec_found;
      end

      if (state_q == S_LATCH) tgt_wdata <= cpu_wdata;
      if (state_q == S_DONE)  tgt_sel   <= '0;

      if (cap_rdata)       cpu_rdata <= sel_rdata;
      else if (force_ones) cpu_rdata <= '1;

      if (state_q != state_d)
        wcnt_q <= '0;
      else if (state_q == S_WAIT || state_q == S_SPECIAL)
        wcnt_q <= wcnt_q + 8'd1;

      if (state_q == S_LATCH)
        tcnt_q <= '0;
      else if (state_q == S_ISSUE || state_q == S_WAIT)
        tcnt_q <= tcnt_q + 8'd1;

      if (set_to)       err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (set_unmap)    err_unmap   <= 1'b1;
      else if (err_clr) err_unmap   <= 1'b0;
    end
  end

  assign tgt_rd  = strobe & ~wr_q;
  assign tgt_wr  = strobe & wr_q;
  assign ready_n = (state_q != S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign na_n    = 1'b1;

endmodule
